dsi_video_timing_gen: RTL and testbench
=======================================

// Module: dsi_video_timing_gen
// PURPOSE
//  Upstream pixel-source stage for the DSI video path, in the pclk domain.
//  Generates the raster timing (hsync, vsync, data_valid) that drives line_fifo,
//  and pulls RGB888 pixels from a ready/valid source during the active window.
//  Programmable enable; flags source underflow for the AHB status register.
// PARAMETERS
//  H_ACTIVE  1280  active pixels per line (equals line_fifo FRAME_LENGTH)
//  H_SYNC    4     hsync width, pclk cycles
//  H_BP      8     horizontal back porch, cycles
//  H_FP      8     horizontal front porch, cycles
//  V_ACTIVE  720   active lines per frame (equals FRAME_DEPTH)
//  V_SYNC    2     vsync width, lines
//  V_BP      4     vertical back porch, lines
//  V_FP      4     vertical front porch, lines
// PORTS
//  pclk          in   1   pixel clock
//  dsi_rst       in   1   asynchronous active-low reset
//  enable        in   1   start/continue video generation (level)
//  src_pixel     in   24  source pixel, RGB888
//  src_valid     in   1   src_pixel valid
//  src_ready     out  1   pixel accepted this cycle (= active window)
//  pixel_data    out  24  pixel to line_fifo
//  data_valid    out  1   pixel_data valid (active window)
//  hsync         out  1   line sync, active-high
//  vsync         out  1   frame sync, active-high
//  frame_start   out  1   1-cycle pulse, first cycle of vsync
//  line_cnt      out  11  current active line index, 0..V_ACTIVE-1
//  underflow     out  1   sticky: active cycle with src_valid=0
//  clr_underflow in   1   clears underflow (clear wins over a same-cycle set)
// BEHAVIOUR
//  - Reset: all outputs 0; h/v FSMs in IDLE; counters 0.
//  - H FSM: IDLE->SYNC(H_SYNC)->BP(H_BP)->ACT(H_ACTIVE)->FP(H_FP)->SYNC; h_cnt
//    counts within state, reloads 0 on transition. Line = H_SYNC+H_BP+H_ACTIVE+H_FP.
//  - V FSM advances at the last FP cycle of each line:
//    VSYNC(V_SYNC)->VBP(V_BP)->VACT(V_ACTIVE)->VFP(V_FP)->VSYNC.
//  - hsync=1 in H SYNC on every line; vsync=1 for all cycles of VSYNC lines.
//  - Active window = H ACT && V VACT. src_ready is combinational on the window.
//  - Outputs registered: pixel_data/data_valid lag src_ready by 1 cycle;
//    hsync/vsync delayed to match, keeping the raster aligned.
//  - Handshake: transfer when src_ready&&src_valid. Window cycle with
//    src_valid=0 -> data_valid still 1, pixel_data=24'h0, underflow set.
//    Timing never stalls.
//  - line_cnt increments at end of each VACT line, returns to 0 at VFP entry.
//  - enable 0->1 in IDLE: enter SYNC/VSYNC next cycle, frame_start pulses.
//  - enable deasserted mid-frame: current frame completes through VFP, then IDLE
//    (no partial frame to line_fifo). Re-asserted before VFP end: no IDLE gap.
//  - Mid-frame reset: immediate return to reset values; next frame restarts at
//    VSYNC line 0.
//  - Counter widths: 12 bits horizontal, 11 bits vertical; parameters must fit.
// CONFIGURATION
//  DSI_TPG_EN defined: internal 8-bar colour pattern replaces src_pixel.
//    Bar = h_cnt/(H_ACTIVE/8), colours white,yellow,cyan,green,magenta,red,
//    blue,black (24'hFFFFFF..24'h000000). src_ready tied 0; underflow never set.
//  DSI_TPG_EN undefined: pattern logic absent; pixels taken from src_pixel.
// TESTING (bench params H_ACTIVE=8,H_SYNC=2,H_BP=2,H_FP=2,V_ACTIVE=4,V_SYNC=1,V_BP=1,V_FP=1)
//  1 reset low, enable=1 -> all outputs 0; after release frame_start pulses once,
//    line period 14 cycles, frame 7 lines = 98 cycles.
//  2 src_valid=1, src_pixel=incrementing 1.. -> 8 data_valid per line for 4 lines,
//    pixel_data 1..32 in order, 1 cycle after src_ready; underflow stays 0.
//  3 src_valid=0 on the 3rd active cycle of line 1 -> pixel_data=0 with
//    data_valid=1 that cycle, underflow=1 until clr_underflow pulse.
//  4 enable dropped during line 2 -> frame completes to VFP end, then hsync/vsync
//    stay 0; re-enable -> new frame_start, line_cnt=0.
//  5 dsi_rst asserted mid ACT -> outputs 0 same cycle; restart gives full frame.
//  6 DSI_TPG_EN defined -> line pixels FFFFFF,FFFF00,00FFFF,00FF00,FF00FF,
//    FF0000,0000FF,000000; src_ready always 0.

Source files
------------

// File: rtl/dsi_video_timing_gen.sv
// Raster timing generator for the DSI video path: hsync/vsync/data_valid plus a ready/valid
// pixel pull. Define DSI_TPG_EN to replace the source with an internal 8-bar colour pattern.
module dsi_video_timing_gen #(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned H_SYNC   = 4,
  parameter int unsigned H_BP     = 8,
  parameter int unsigned H_FP     = 8,
  parameter int unsigned V_ACTIVE = 720,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 4,
  parameter int unsigned V_FP     = 4
) (
  input  logic        pclk,
  input  logic        dsi_rst,
  input  logic        enable,
  input  logic [23:0] src_pixel,
  input  logic        src_valid,
  output logic        src_ready,
  output logic [23:0] pixel_data,
  output logic        data_valid,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start,
  output logic [10:0] line_cnt,
  output logic        underflow,
  input  logic        clr_underflow
);

  if (H_SYNC == 0 || H_BP == 0 || H_ACTIVE == 0 || H_FP == 0 ||
      H_SYNC > 4096 || H_BP > 4096 || H_ACTIVE > 4096 || H_FP > 4096 ||
      V_SYNC == 0 || V_BP == 0 || V_ACTIVE == 0 || V_FP == 0 ||
      V_SYNC > 2048 || V_BP > 2048 || V_ACTIVE > 2048 || V_FP > 2048) begin : g_bad_params
    $error("dsi_video_timing_gen: timing parameters do not fit the counters");
  end

  typedef enum logic [2:0] {HIdle, HSync, HBp, HAct, HFp} h_state_e;
  typedef enum logic [2:0] {VIdle, VSync, VBp, VAct, VFp} v_state_e;

  localparam logic [11:0] HSyncLast = 12'(H_SYNC - 1);
  localparam logic [11:0] HBpLast   = 12'(H_BP - 1);
  localparam logic [11:0] HActLast  = 12'(H_ACTIVE - 1);
  localparam logic [11:0] HFpLast   = 12'(H_FP - 1);
  localparam logic [10:0] VSyncLast = 11'(V_SYNC - 1);
  localparam logic [10:0] VBpLast   = 11'(V_BP - 1);
  localparam logic [10:0] VActLast  = 11'(V_ACTIVE - 1);
  localparam logic [10:0] VFpLast   = 11'(V_FP - 1);

  h_state_e    h_state_q, h_state_d;
  v_state_e    v_state_q, v_state_d;
  logic [11:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;
  logic [11:0] h_last;
  logic [10:0] v_last;
  logic        line_end, frame_end;

  logic [23:0] pixel_data_q, pixel_data_d;
  logic        data_valid_q, data_valid_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        frame_start_q, frame_start_d;
  logic [10:0] line_cnt_q, line_cnt_d;
  logic        underflow_q, underflow_d;
  logic        win;

  always_comb begin
    unique case (h_state_q)
      HSync:   h_last = HSyncLast;
      HBp:     h_last = HBpLast;
      HAct:    h_last = HActLast;
      HFp:     h_last = HFpLast;
      default: h_last = '0;
    endcase
    unique case (v_state_q)
      VSync:   v_last = VSyncLast;
      VBp:     v_last = VBpLast;
      VAct:    v_last = VActLast;
      VFp:     v_last = VFpLast;
      default: v_last = '0;
    endcase
  end

  // Both FSMs leave and re-enter idle together; enable is only sampled in idle and at frame end.
  always_comb begin
    h_state_d = h_state_q;
    h_cnt_d   = h_cnt_q;
    v_state_d = v_state_q;
    v_cnt_d   = v_cnt_q;
    line_end  = (h_state_q == HFp) && (h_cnt_q == HFpLast);
    frame_end = line_end && (v_state_q == VFp) && (v_cnt_q == VFpLast);

    if (h_state_q == HIdle) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
      if (enable) begin
        h_state_d = HSync;
        v_state_d = VSync;
      end
    end else begin
      if (h_cnt_q == h_last) begin
        h_cnt_d = '0;
        unique case (h_state_q)
          HSync:   h_state_d = HBp;
          HBp:     h_state_d = HAct;
          HAct:    h_state_d = HFp;
          HFp:     h_state_d = (frame_end && !enable) ? HIdle : HSync;
          default: h_state_d = HIdle;
        endcase
      end else begin
        h_cnt_d = h_cnt_q + 12'd1;
      end

      if (line_end) begin
        if (v_cnt_q == v_last) begin
          v_cnt_d = '0;
          unique case (v_state_q)
            VSync:   v_state_d = VBp;
            VBp:     v_state_d = VAct;
            VAct:    v_state_d = VFp;
            VFp:     v_state_d = enable ? VSync : VIdle;
            default: v_state_d = VIdle;
          endcase
        end else begin
          v_cnt_d = v_cnt_q + 11'd1;
        end
      end
    end
  end

  assign win = (h_state_q == HAct) && (v_state_q == VAct);

`ifdef DSI_TPG_EN
  localparam int unsigned BarWidth = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

  logic [11:0] bar_idx;
  logic [23:0] tpg_pixel;
  logic        unused_src;

  assign unused_src = ^{src_pixel, src_valid};
  assign bar_idx    = h_cnt_q / 12'(BarWidth);

  always_comb begin
    case (bar_idx)
      12'd0:   tpg_pixel = 24'hFFFFFF;
      12'd1:   tpg_pixel = 24'hFFFF00;
      12'd2:   tpg_pixel = 24'h00FFFF;
      12'd3:   tpg_pixel = 24'h00FF00;
      12'd4:   tpg_pixel = 24'hFF00FF;
      12'd5:   tpg_pixel = 24'hFF0000;
      12'd6:   tpg_pixel = 24'h0000FF;
      default: tpg_pixel = 24'h000000;
    endcase
  end

  assign src_ready = 1'b0;
`else
  assign src_ready = win;
`endif

  // Registered outputs are all taken from the same cycle's state so the raster stays aligned.
  always_comb begin
    data_valid_d  = win;
    hsync_d       = (h_state_q == HSync);
    vsync_d       = (v_state_q == VSync);
    frame_start_d = (h_state_q == HSync) && (v_state_q == VSync) &&
                    (h_cnt_q == '0) && (v_cnt_q == '0);
    line_cnt_d    = (v_state_q == VAct) ? v_cnt_q : '0;
`ifdef DSI_TPG_EN
    pixel_data_d  = win ? tpg_pixel : '0;
    underflow_d   = clr_underflow ? 1'b0 : underflow_q;
`else
    pixel_data_d  = (win && src_valid) ? src_pixel : '0;
    underflow_d   = clr_underflow ? 1'b0 : (underflow_q | (win & ~src_valid));
`endif
  end

  always_ff @(posedge pclk or negedge dsi_rst) begin
    if (!dsi_rst) begin
      h_state_q     <= HIdle;
      v_state_q     <= VIdle;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      pixel_data_q  <= '0;
      data_valid_q  <= 1'b0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      frame_start_q <= 1'b0;
      line_cnt_q    <= '0;
      underflow_q   <= 1'b0;
    end else begin
      h_state_q     <= h_state_d;
      v_state_q     <= v_state_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      pixel_data_q  <= pixel_data_d;
      data_valid_q  <= data_valid_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
      line_cnt_q    <= line_cnt_d;
      underflow_q   <= underflow_d;
    end
  end

  assign pixel_data  = pixel_data_q;
  assign data_valid  = data_valid_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = frame_start_q;
  assign line_cnt    = line_cnt_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_dsi_video_timing_gen.sv
// Bench for dsi_video_timing_gen: a frame-position model predicts every output each cycle,
// plus literal checks on frame/line periods, pixel order, underflow, enable drain and reset.
module tb_dsi_video_timing_gen;

  localparam int HA = 8, HS = 2, HB = 2, HF = 2;
  localparam int VA = 4, VS = 1, VB = 1, VF = 1;
  localparam int HT = HS + HB + HA + HF;
  localparam int VT = VS + VB + VA + VF;
  localparam int FT = HT * VT;

  logic        pclk = 1'b0;
  logic        dsi_rst, enable, src_valid, clr_underflow;
  logic [23:0] src_pixel;
  logic        src_ready, data_valid, hsync, vsync, frame_start, underflow;
  logic [23:0] pixel_data;
  logic [10:0] line_cnt;

  dsi_video_timing_gen #(
    .H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HB), .H_FP(HF),
    .V_ACTIVE(VA), .V_SYNC(VS), .V_BP(VB), .V_FP(VF)
  ) dut (
    .pclk         (pclk),
    .dsi_rst      (dsi_rst),
    .enable       (enable),
    .src_pixel    (src_pixel),
    .src_valid    (src_valid),
    .src_ready    (src_ready),
    .pixel_data   (pixel_data),
    .data_valid   (data_valid),
    .hsync        (hsync),
    .vsync        (vsync),
    .frame_start  (frame_start),
    .line_cnt     (line_cnt),
    .underflow    (underflow),
    .clr_underflow(clr_underflow)
  );

  always #5 pclk = ~pclk;

  // Model: a running flag and the cycle position within the frame.
  bit          m_run;
  int          m_pos;
  logic        exp_dv, exp_hs, exp_vs, exp_fs, exp_uf;
  logic [23:0] exp_pix;
  logic [10:0] exp_line;
  logic [23:0] next_pix;
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  int          vmode, cyc, n_err, n_chk;
  bit          hole_arm, hole_now, chk_en;

  function automatic int lin(input int p); return p / HT; endfunction
  function automatic int col(input int p); return p % HT; endfunction
  function automatic bit in_win(input int p);
    return lin(p) >= VS + VB && lin(p) < VS + VB + VA && col(p) >= HS + HB && col(p) < HS + HB + HA;
  endfunction

  function automatic bit exp_rdy();
`ifdef DSI_TPG_EN
    return 1'b0;
`else
    return m_run && in_win(m_pos);
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_pos = 0;
    exp_dv = 0; exp_hs = 0; exp_vs = 0; exp_fs = 0; exp_uf = 0; exp_pix = '0; exp_line = '0;
  endtask

  task automatic model_edge();
    bit w;
    w        = m_run && in_win(m_pos);
    exp_dv   = w;
    exp_hs   = m_run && col(m_pos) < HS;
    exp_vs   = m_run && lin(m_pos) < VS;
    exp_fs   = m_run && m_pos == 0;
    exp_line = (m_run && lin(m_pos) >= VS + VB && lin(m_pos) < VS + VB + VA) ?
               11'(lin(m_pos) - VS - VB) : 11'd0;
`ifdef DSI_TPG_EN
    exp_pix = w ? bars[(col(m_pos) - HS - HB) / (HA / 8)] : 24'h0;
    if (clr_underflow) exp_uf = 0;
`else
    exp_pix = (w && src_valid) ? src_pixel : 24'h0;
    if (w && src_valid) next_pix++;
    if (clr_underflow) exp_uf = 0;
    else if (w && !src_valid) exp_uf = 1;
`endif
    if (!m_run) begin
      if (enable) begin m_run = 1; m_pos = 0; end
    end else begin
      m_pos++;
      if (m_pos == FT) begin
        m_pos = 0;
        if (!enable) m_run = 0;
      end
    end
  endtask

  task automatic drive();
    src_pixel = next_pix;
    src_valid = (vmode == 0) ? 1'b1 : ($urandom_range(0, 7) != 0);
    hole_now  = 0;
    if (hole_arm && m_run && in_win(m_pos) && lin(m_pos) == VS + VB + 1 &&
        col(m_pos) == HS + HB + 2) begin
      src_valid = 0; hole_arm = 0; hole_now = 1;
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    if (dsi_rst) model_edge();
    cyc++;
    #1;
    drive();
  endtask

  always @(negedge pclk) begin
    if (chk_en) begin
      check("src_ready", src_ready, exp_rdy());
      check("data_valid", data_valid, exp_dv);
      check("pixel_data", pixel_data, exp_pix);
      check("hsync", hsync, exp_hs);
      check("vsync", vsync, exp_vs);
      check("frame_start", frame_start, exp_fs);
      check("line_cnt", line_cnt, exp_line);
      check("underflow", underflow, exp_uf);
    end
  end

  int fs_n, fs1, fs2, hs_r1, hs_r2, dv_n, pix_bad, idle_bad, fs_wait, fs_t, lc_at_fs;
  bit hs_prev, found, was;
  logic [23:0] pixq [32];

  initial begin
    dsi_rst = 0; enable = 1; src_pixel = '0; src_valid = 1; clr_underflow = 0;
    vmode = 0; next_pix = 24'd1; hole_arm = 0; hole_now = 0; cyc = 0; n_err = 0; n_chk = 0;
    model_reset();
    chk_en = 1;
    repeat (3) @(negedge pclk);
    check("rst_ctl", {26'b0, hsync, vsync, frame_start, data_valid, underflow, src_ready}, 0);
    check("rst_pix_line", {pixel_data, line_cnt}, 0);
    tick();
    dsi_rst = 1;

    // Frame/line periods and in-order pixels.
    fs_n = 0; fs1 = 0; fs2 = 0; hs_r1 = -1; hs_r2 = -1; dv_n = 0; hs_prev = 0;
    for (int t = 1; t <= 200; t++) begin
      tick();
      if (frame_start) begin
        if (fs_n == 0) fs1 = t; else if (fs_n == 1) fs2 = t;
        fs_n++;
      end
      if (hsync && !hs_prev) begin
        if (hs_r1 < 0) hs_r1 = t; else if (hs_r2 < 0) hs_r2 = t;
      end
      hs_prev = hsync;
      if (data_valid && t < 2 + FT) begin
        if (dv_n < 32) pixq[dv_n] = pixel_data;
        dv_n++;
      end
    end
    check("first_fs_cycle", fs1, 2);
    check("frame_period", fs2 - fs1, 98);
    check("fs_pulses", fs_n, 3);
    check("line_period", hs_r2 - hs_r1, 14);
    check("dv_per_frame", dv_n, 32);
`ifdef DSI_TPG_EN
    for (int i = 0; i < 8; i++) check("tpg_bar", pixq[i], bars[i]);
`else
    pix_bad = 0;
    for (int i = 0; i < 32; i++) if (pixq[i] !== 24'(i + 1)) pix_bad++;
    check("pix_seq", pix_bad, 0);
    check("uf_clean", underflow, 0);

    // Source hole on the 3rd active cycle of active line 1.
    hole_arm = 1; found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      was = hole_now;
      tick();
      if (was) begin
        check("hole_dv", data_valid, 1);
        check("hole_pix", pixel_data, 0);
        check("hole_uf", underflow, 1);
        found = 1;
      end
    end
    check("hole_found", found, 1);
    repeat (20) tick();
    check("uf_sticky", underflow, 1);
    clr_underflow = 1;
    tick();
    clr_underflow = 0;
    check("uf_clear", underflow, 0);
`endif

    // Enable dropped during active line 2: frame drains, then silence.
    for (int i = 0; i < 300 && !(m_run && lin(m_pos) == VS + VB + 2); i++) tick();
    enable = 0;
    dv_n = 0;
    for (int i = 0; i < 300 && m_run; i++) begin tick(); if (data_valid) dv_n++; end
    idle_bad = 0;
    repeat (30) begin
      tick();
      if (data_valid) dv_n++;
      if (hsync || vsync || data_valid || frame_start) idle_bad++;
    end
    check("drain_dv", dv_n, 16);
    check("idle_quiet", idle_bad, 0);
    enable = 1;
    fs_wait = 0; lc_at_fs = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (frame_start && fs_wait == 0) begin fs_wait = i; fs_t = cyc; lc_at_fs = line_cnt; end
    end
    check("restart_fs", fs_wait, 2);
    check("restart_line", lc_at_fs, 0);

    // Enable pulsed low but back before VFP end: no idle gap.
    for (int i = 0; i < 300 && !(m_run && lin(m_pos) == VS + VB + 1); i++) tick();
    enable = 0;
    for (int i = 0; i < 300 && !(m_run && lin(m_pos) == VT - 1); i++) tick();
    enable = 1;
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      tick();
      if (frame_start) found = 1;
    end
    check("nogap_period", cyc - fs_t, 98);

    // Asynchronous reset in the middle of an active line.
    for (int i = 0; i < 300 && !(m_run && in_win(m_pos) && lin(m_pos) == VS + VB + 1); i++) tick();
    #2;
    dsi_rst = 0;
    model_reset();
    #1;
    check("rst_async_ctl", {26'b0, hsync, vsync, frame_start, data_valid, underflow, src_ready}, 0);
    check("rst_async_pix", pixel_data, 0);
    tick();
    dsi_rst = 1;
    fs_wait = 0; dv_n = 0;
    for (int t = 1; t < 2 + FT; t++) begin
      tick();
      if (frame_start && fs_wait == 0) fs_wait = t;
      if (data_valid) dv_n++;
    end
    check("rst_restart_fs", fs_wait, 2);
    check("rst_restart_dv", dv_n, 32);

    // Randomised traffic, enable toggles, clears and one reset.
    vmode = 1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 299) == 0) enable = ~enable;
      clr_underflow = ($urandom_range(0, 29) == 0);
      if (i == 1200) begin
        #2;
        dsi_rst = 0;
        model_reset();
        tick();
        dsi_rst = 1;
      end
      tick();
    end
    clr_underflow = 0;
    enable = 1;
    repeat (5) tick();

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
